// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard decoder: FSM encodings,
// protocol bytes, modifier scancodes, translated key codes and FIFO size.
package kbd_pkg;

  typedef enum logic [2:0] {
    P_IDLE,
    P_EXT,
    P_BRK,
    P_EXTBRK,
    P_SKIP
  } prefix_state_t;

  typedef enum logic [2:0] {
    L_IDLE,
    L_CMD1,
    L_ACK1,
    L_CMD2,
    L_ACK2
  } led_state_t;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_ED = 8'hED;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] KEY_BKSP  = 8'h08;
  localparam logic [7:0] KEY_TAB   = 8'h09;
  localparam logic [7:0] KEY_ENTER = 8'h0A;
  localparam logic [7:0] KEY_ESC   = 8'h1B;
  localparam logic [7:0] KEY_DEL   = 8'h7F;
  localparam logic [7:0] KEY_UP    = 8'h80;
  localparam logic [7:0] KEY_DOWN  = 8'h81;
  localparam logic [7:0] KEY_LEFT  = 8'h82;
  localparam logic [7:0] KEY_RIGHT = 8'h83;
  localparam logic [7:0] KEY_HOME  = 8'h84;
  localparam logic [7:0] KEY_END   = 8'h85;
  localparam logic [7:0] KEY_PGUP  = 8'h86;
  localparam logic [7:0] KEY_PGDN  = 8'h87;
  localparam logic [7:0] KEY_INS   = 8'h88;
  localparam logic [7:0] KEY_F1    = 8'h90;

  localparam int FIFO_DEPTH = 16;

  // Controller/keyboard status bytes that carry no key information when idle.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/kbd_xlat.sv
// Combinational scancode (set 2, US layout) to key-code translation.
module kbd_xlat
  import kbd_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  input  logic       ctrl,
  output logic       valid,
  output logic [7:0] code
);

  logic [7:0] letter;
  logic [7:0] upper;

  // Lowercase ASCII for the 26 letter keys, zero for anything else.
  always_comb begin
    letter = 8'h00;
    if (!ext) begin
      case (scancode)
        8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
        8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
        8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
        8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
        8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
        8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
        8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
        8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
        8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
        default: letter = 8'h00;
      endcase
    end
  end

  assign upper = letter - 8'h20;

  // Final code: letters honour ctrl/shift/caps, other printables only shift.
  always_comb begin
    valid = 1'b0;
    code  = 8'h00;
    if (letter != 8'h00) begin
      valid = 1'b1;
      if (ctrl)              code = upper & 8'h1F;
      else if (shift ^ caps) code = upper;
      else                   code = letter;
    end else if (ext) begin
      valid = 1'b1;
      case (scancode)
        8'h75: code = KEY_UP;
        8'h72: code = KEY_DOWN;
        8'h6B: code = KEY_LEFT;
        8'h74: code = KEY_RIGHT;
        8'h6C: code = KEY_HOME;
        8'h69: code = KEY_END;
        8'h7D: code = KEY_PGUP;
        8'h7A: code = KEY_PGDN;
        8'h70: code = KEY_INS;
        8'h71: code = KEY_DEL;
        default: valid = 1'b0;
      endcase
    end else begin
      valid = 1'b1;
      case (scancode)
        8'h16: code = shift ? 8'h21 : 8'h31;
        8'h1E: code = shift ? 8'h40 : 8'h32;
        8'h26: code = shift ? 8'h23 : 8'h33;
        8'h25: code = shift ? 8'h24 : 8'h34;
        8'h2E: code = shift ? 8'h25 : 8'h35;
        8'h36: code = shift ? 8'h5E : 8'h36;
        8'h3D: code = shift ? 8'h26 : 8'h37;
        8'h3E: code = shift ? 8'h2A : 8'h38;
        8'h46: code = shift ? 8'h28 : 8'h39;
        8'h45: code = shift ? 8'h29 : 8'h30;
        8'h0E: code = shift ? 8'h7E : 8'h60;
        8'h4E: code = shift ? 8'h5F : 8'h2D;
        8'h55: code = shift ? 8'h2B : 8'h3D;
        8'h54: code = shift ? 8'h7B : 8'h5B;
        8'h5B: code = shift ? 8'h7D : 8'h5D;
        8'h5D: code = shift ? 8'h7C : 8'h5C;
        8'h4C: code = shift ? 8'h3A : 8'h3B;
        8'h52: code = shift ? 8'h22 : 8'h27;
        8'h41: code = shift ? 8'h3C : 8'h2C;
        8'h49: code = shift ? 8'h3E : 8'h2E;
        8'h4A: code = shift ? 8'h3F : 8'h2F;
        8'h29: code = 8'h20;
        8'h5A: code = KEY_ENTER;
        8'h66: code = KEY_BKSP;
        8'h0D: code = KEY_TAB;
        8'h76: code = KEY_ESC;
        8'h05: code = KEY_F1;
        8'h06: code = KEY_F1 + 8'd1;
        8'h04: code = KEY_F1 + 8'd2;
        8'h0C: code = KEY_F1 + 8'd3;
        8'h03: code = KEY_F1 + 8'd4;
        8'h0B: code = KEY_F1 + 8'd5;
        8'h83: code = KEY_F1 + 8'd6;
        8'h0A: code = KEY_F1 + 8'd7;
        8'h01: code = KEY_F1 + 8'd8;
        8'h09: code = KEY_F1 + 8'd9;
        8'h78: code = KEY_F1 + 8'd10;
        8'h07: code = KEY_F1 + 8'd11;
        default: valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/kbd_decoder.sv
// PS/2 keyboard decoder: prefix tracking, modifier state, key FIFO and the
// caps-lock LED update handshake (ED + LED byte, each acknowledged by FA).
module kbd_decoder
  import kbd_pkg::*;
#(
  parameter int ACK_TIMEOUT_W = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] kbd,
  input  logic       hit,
  input  logic       err,
  input  logic       ready,
  output logic       cmd,
  output logic [7:0] dat,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       empty,
  output logic       ovf,
  output logic [3:0] mods
);

  prefix_state_t          p_state;
  logic [2:0]             skip_cnt;
  led_state_t             l_state;
  logic                   led_pend;
  logic [ACK_TIMEOUT_W-1:0] tmo_cnt;

  logic lshift, rshift, lctrl, rctrl, lalt, ralt, caps_held, caps_lock;

  logic [7:0] fifo_mem [FIFO_DEPTH];
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] count;

  logic ack_wait, ack_hit, feed, is_ext, is_brk, is_prefix, key_evt;
  logic k_lshift, k_rshift, k_lctrl, k_rctrl, k_lalt, k_ralt, k_caps, k_mod;
  logic x_valid;
  logic [7:0] x_code;
  logic push_req, caps_toggle, full, do_pop, do_push;

  assign mods = {caps_lock, lalt | ralt, lctrl | rctrl, lshift | rshift};

  // An FA arriving while the LED handshake waits belongs to it, not to the key path.
  assign ack_wait  = (l_state == L_ACK1) || (l_state == L_ACK2);
  assign ack_hit   = hit && ack_wait && (kbd == SC_FA);
  assign feed      = hit && !err && !ack_hit;
  assign is_ext    = (p_state == P_EXT) || (p_state == P_EXTBRK);
  assign is_brk    = (p_state == P_BRK) || (p_state == P_EXTBRK);
  assign is_prefix = (kbd == SC_E0) || (kbd == SC_F0) ||
                     ((kbd == SC_E1) && (p_state == P_IDLE));
  assign key_evt   = feed && (p_state != P_SKIP) && !is_prefix &&
                     !((p_state == P_IDLE) && is_ignored(kbd));

  assign k_lshift = !is_ext && (kbd == SC_LSHIFT);
  assign k_rshift = !is_ext && (kbd == SC_RSHIFT);
  assign k_lctrl  = !is_ext && (kbd == SC_CTRL);
  assign k_rctrl  =  is_ext && (kbd == SC_CTRL);
  assign k_lalt   = !is_ext && (kbd == SC_ALT);
  assign k_ralt   =  is_ext && (kbd == SC_ALT);
  assign k_caps   = !is_ext && (kbd == SC_CAPS);
  assign k_mod    = k_lshift | k_rshift | k_lctrl | k_rctrl | k_lalt | k_ralt | k_caps;

  kbd_xlat u_xlat (
    .scancode (kbd),
    .ext      (is_ext),
    .shift    (mods[0]),
    .caps     (caps_lock),
    .ctrl     (mods[1]),
    .valid    (x_valid),
    .code     (x_code)
  );

  assign push_req    = key_evt && !is_brk && !k_mod && x_valid;
  assign caps_toggle = key_evt && !is_brk && k_caps && !caps_held;

  assign empty   = (count == 5'd0);
  assign full    = (count == 5'(FIFO_DEPTH));
  assign do_pop  = rd && !empty;
  assign do_push = push_req && (!full || do_pop);
  assign dout    = empty ? 8'h00 : fifo_mem[rd_ptr];

  // Prefix FSM: tracks E0/F0/E1 prefixes and swallows the Pause sequence.
  always_ff @(posedge clock) begin
    if (reset || err) begin
      p_state  <= P_IDLE;
      skip_cnt <= 3'd0;
    end else if (feed) begin
      if (p_state == P_SKIP) begin
        if (skip_cnt == 3'd6) begin
          p_state  <= P_IDLE;
          skip_cnt <= 3'd0;
        end else begin
          skip_cnt <= skip_cnt + 3'd1;
        end
      end else if (kbd == SC_E0) begin
        p_state <= P_EXT;
      end else if (kbd == SC_F0) begin
        p_state <= is_ext ? P_EXTBRK : P_BRK;
      end else if ((kbd == SC_E1) && (p_state == P_IDLE)) begin
        p_state  <= P_SKIP;
        skip_cnt <= 3'd0;
      end else begin
        p_state <= P_IDLE;
      end
    end
  end

  // Modifier held bits; caps lock flips only on a fresh (non-repeat) make.
  always_ff @(posedge clock) begin
    if (reset) begin
      {lshift, rshift, lctrl, rctrl, lalt, ralt, caps_held, caps_lock} <= '0;
    end else if (key_evt) begin
      if (k_lshift) lshift <= !is_brk;
      if (k_rshift) rshift <= !is_brk;
      if (k_lctrl)  lctrl  <= !is_brk;
      if (k_rctrl)  rctrl  <= !is_brk;
      if (k_lalt)   lalt   <= !is_brk;
      if (k_ralt)   ralt   <= !is_brk;
      if (k_caps)   caps_held <= !is_brk;
      if (caps_toggle) caps_lock <= !caps_lock;
    end
  end

  // FIFO storage; the slot freed by a pop may be refilled in the same cycle.
  always_ff @(posedge clock) begin
    if (do_push) fifo_mem[wr_ptr] <= x_code;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 4'd0;
      rd_ptr <= 4'd0;
      count  <= 5'd0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 4'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 4'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (do_pop)                     ovf <= 1'b0;
      else if (push_req && !do_push)  ovf <= 1'b1;
    end
  end

  // LED FSM: sends ED then the LED byte, waiting for FA after each, with abort.
  always_ff @(posedge clock) begin
    if (reset) begin
      l_state  <= L_IDLE;
      led_pend <= 1'b0;
      tmo_cnt  <= '0;
      cmd      <= 1'b0;
      dat      <= 8'h00;
    end else begin
      cmd <= 1'b0;
      dat <= 8'h00;
      if (caps_toggle)                         led_pend <= 1'b1;
      else if ((l_state == L_IDLE) && led_pend) led_pend <= 1'b0;
      case (l_state)
        L_IDLE: if (led_pend) l_state <= L_CMD1;
        L_CMD1, L_CMD2: begin
          if (ready) begin
            cmd     <= 1'b1;
            dat     <= (l_state == L_CMD1) ? SC_ED : {5'b0, caps_lock, 2'b0};
            l_state <= (l_state == L_CMD1) ? L_ACK1 : L_ACK2;
            tmo_cnt <= '0;
          end
        end
        L_ACK1, L_ACK2: begin
          if (err)          l_state <= L_IDLE;
          else if (ack_hit) l_state <= (l_state == L_ACK1) ? L_CMD2 : L_IDLE;
          else if (hit)     l_state <= L_IDLE;
          else if (&tmo_cnt) l_state <= L_IDLE;
          else              tmo_cnt <= tmo_cnt + 1'b1;
        end
        default: l_state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_decoder.sv
// Directed bench for kbd_decoder: a vector table for the key path plus
// hand-written sequences for the LED handshake, timeout, reset and FIFO limits.
module tb_kbd_decoder;

  logic       clock = 1'b0;
  logic       reset, hit, err, ready, rd;
  logic [7:0] kbd;
  logic       cmd, empty, ovf;
  logic [7:0] dat, dout;
  logic [3:0] mods;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] kbd;
    logic       hit;
    logic       rd;
    logic       err;
    logic       exp_empty;
    logic [7:0] exp_dout;
    logic [3:0] exp_mods;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] letter_codes [16] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D};

  // The ack timeout is shortened here so the abort path fits a short run.
  kbd_decoder #(.ACK_TIMEOUT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .kbd   (kbd),
    .hit   (hit),
    .err   (err),
    .ready (ready),
    .cmd   (cmd),
    .dat   (dat),
    .rd    (rd),
    .dout  (dout),
    .empty (empty),
    .ovf   (ovf),
    .mods  (mods)
  );

  always #20 clock = ~clock;

  initial begin
    #(40 * 40000);
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [7:0] b, input logic h, input logic r, input logic e,
                              input logic x_empty, input logic [7:0] x_dout,
                              input logic [3:0] x_mods, input logic x_ovf);
    vec_t v;
    v.kbd = b; v.hit = h; v.rd = r; v.err = e;
    v.exp_empty = x_empty; v.exp_dout = x_dout; v.exp_mods = x_mods; v.exp_ovf = x_ovf;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic h, input logic r, input logic e);
    kbd = b; hit = h; rd = r; err = e;
    tick();
    kbd = 8'h00; hit = 1'b0; rd = 1'b0; err = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic popOne();
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic waitCmd(input int max_cycles, output logic seen, output logic [7:0] seen_dat);
    seen = 1'b0;
    seen_dat = 8'h00;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      if (cmd) begin
        seen = 1'b1;
        seen_dat = dat;
      end else begin
        tick();
      end
    end
  endtask

  task automatic expectCmd(input string name, input logic [7:0] exp_dat);
    logic       seen;
    logic [7:0] d;
    waitCmd(20, seen, d);
    checkOutput({name, " cmd"}, 32'(seen), 32'd1);
    checkOutput({name, " dat"}, 32'(d), 32'(exp_dat));
  endtask

  task automatic expectNoCmd(input string name, input int cycles);
    logic       seen;
    logic [7:0] d;
    waitCmd(cycles, seen, d);
    checkOutput(name, 32'(seen), 32'd0);
  endtask

  task automatic drainExpect(input string name, input int n, input logic [7:0] start, input int step);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = 8'(int'(start) + i * step);
      checkOutput($sformatf("%s empty[%0d]", name, i), 32'(empty), 32'd0);
      checkOutput($sformatf("%s dout[%0d]", name, i), 32'(dout), 32'(e));
      popOne();
    end
    checkOutput({name, " final empty"}, 32'(empty), 32'd1);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " cmd"},   32'(cmd),   32'd0);
    checkOutput({name, " dat"},   32'(dat),   32'h00);
    checkOutput({name, " empty"}, 32'(empty), 32'd1);
    checkOutput({name, " dout"},  32'(dout),  32'h00);
    checkOutput({name, " ovf"},   32'(ovf),   32'd0);
    checkOutput({name, " mods"},  32'(mods),  32'h0);
  endtask

  initial begin
    reset = 1'b1; hit = 1'b0; err = 1'b0; ready = 1'b0; rd = 1'b0; kbd = 8'h00;
    repeat (3) tick();
    checkResetState("reset");
    reset = 1'b0;

    // kbd, hit, rd, err | empty, dout, mods, ovf
    vecs.push_back(mk(8'h12, 1, 0, 0, 1, 8'h00, 4'h1, 0));
    vecs.push_back(mk(8'h1C, 1, 0, 0, 0, 8'h41, 4'h1, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 0, 0, 8'h41, 4'h1, 0));
    vecs.push_back(mk(8'h1C, 1, 0, 0, 0, 8'h41, 4'h1, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 0, 0, 8'h41, 4'h1, 0));
    vecs.push_back(mk(8'h12, 1, 0, 0, 0, 8'h41, 4'h0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h16, 1, 0, 0, 0, 8'h31, 4'h0, 0));
    vecs.push_back(mk(8'h12, 1, 0, 0, 0, 8'h31, 4'h1, 0));
    vecs.push_back(mk(8'h16, 1, 0, 0, 0, 8'h31, 4'h1, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 0, 8'h21, 4'h1, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 0, 0, 8'h21, 4'h1, 0));
    vecs.push_back(mk(8'h12, 1, 0, 0, 0, 8'h21, 4'h0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h14, 1, 0, 0, 1, 8'h00, 4'h2, 0));
    vecs.push_back(mk(8'hE0, 1, 0, 0, 1, 8'h00, 4'h2, 0));
    vecs.push_back(mk(8'h14, 1, 0, 0, 1, 8'h00, 4'h2, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 0, 1, 8'h00, 4'h2, 0));
    vecs.push_back(mk(8'h14, 1, 0, 0, 1, 8'h00, 4'h2, 0));
    vecs.push_back(mk(8'h21, 1, 0, 0, 0, 8'h03, 4'h2, 0));
    vecs.push_back(mk(8'hE0, 1, 0, 0, 0, 8'h03, 4'h2, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 0, 0, 8'h03, 4'h2, 0));
    vecs.push_back(mk(8'h14, 1, 0, 0, 0, 8'h03, 4'h0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'hE0, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h71, 1, 0, 0, 0, 8'h7F, 4'h0, 0));
    vecs.push_back(mk(8'h05, 1, 1, 0, 0, 8'h90, 4'h0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'hFA, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'hAA, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'hFE, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h5A, 1, 0, 0, 0, 8'h0A, 4'h0, 0));
    vecs.push_back(mk(8'hE0, 1, 0, 0, 0, 8'h0A, 4'h0, 0));
    vecs.push_back(mk(8'h75, 1, 0, 0, 0, 8'h0A, 4'h0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 0, 8'h80, 4'h0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'hE0, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h75, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'hE1, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h14, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h77, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'hE1, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h14, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h77, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h1C, 1, 0, 0, 0, 8'h61, 4'h0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h12, 1, 0, 0, 1, 8'h00, 4'h1, 0));
    vecs.push_back(mk(8'hE0, 1, 0, 0, 1, 8'h00, 4'h1, 0));
    vecs.push_back(mk(8'h00, 0, 0, 1, 1, 8'h00, 4'h1, 0));
    vecs.push_back(mk(8'h1C, 1, 0, 0, 0, 8'h41, 4'h1, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 0, 0, 8'h41, 4'h1, 0));
    vecs.push_back(mk(8'h12, 1, 0, 0, 0, 8'h41, 4'h0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h11, 1, 0, 0, 1, 8'h00, 4'h4, 0));
    vecs.push_back(mk(8'hE0, 1, 0, 0, 1, 8'h00, 4'h4, 0));
    vecs.push_back(mk(8'h11, 1, 0, 0, 1, 8'h00, 4'h4, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 0, 1, 8'h00, 4'h4, 0));
    vecs.push_back(mk(8'h11, 1, 0, 0, 1, 8'h00, 4'h4, 0));
    vecs.push_back(mk(8'hE0, 1, 0, 0, 1, 8'h00, 4'h4, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 0, 1, 8'h00, 4'h4, 0));
    vecs.push_back(mk(8'h11, 1, 0, 0, 1, 8'h00, 4'h0, 0));
    vecs.push_back(mk(8'h59, 1, 0, 0, 1, 8'h00, 4'h1, 0));
    vecs.push_back(mk(8'h1A, 1, 0, 0, 0, 8'h5A, 4'h1, 0));
    vecs.push_back(mk(8'hF0, 1, 0, 0, 0, 8'h5A, 4'h1, 0));
    vecs.push_back(mk(8'h59, 1, 0, 0, 0, 8'h5A, 4'h0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 1, 8'h00, 4'h0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].kbd, vecs[i].hit, vecs[i].rd, vecs[i].err);
      checkOutput($sformatf("vec%0d dout", i),  32'(dout),  32'(vecs[i].exp_dout));
      checkOutput($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      checkOutput($sformatf("vec%0d mods", i),  32'(mods),  32'(vecs[i].exp_mods));
      checkOutput($sformatf("vec%0d ovf", i),   32'(ovf),   32'(vecs[i].exp_ovf));
    end

    // Caps make starts the LED update; each FA moves it on.
    ready = 1'b1;
    sendByte(8'h58);
    checkOutput("caps on mods", 32'(mods), 32'h8);
    expectCmd("led ed", 8'hED);
    sendByte(8'hFA);
    expectCmd("led byte on", 8'h04);
    sendByte(8'hFA);
    expectNoCmd("led done", 20);
    checkOutput("acks not queued", 32'(empty), 32'd1);

    // Typematic repeat of a held caps key changes nothing.
    sendByte(8'h58);
    checkOutput("caps repeat mods", 32'(mods), 32'h8);
    expectNoCmd("caps repeat no cmd", 10);
    sendByte(8'hF0);
    sendByte(8'h58);

    // A non-FA byte during the ack wait aborts and is decoded as a key.
    sendByte(8'h58);
    checkOutput("caps off mods", 32'(mods), 32'h0);
    expectCmd("abort ed", 8'hED);
    sendByte(8'h1C);
    checkOutput("abort byte pushed", 32'(dout), 32'h61);
    expectNoCmd("abort no cmd", 10);
    popOne();
    sendByte(8'hF0);
    sendByte(8'h58);

    // Caps toggled while the LED byte is pending: resend with the latest state.
    sendByte(8'h58);
    expectCmd("busy ed", 8'hED);
    ready = 1'b0;
    sendByte(8'hFA);
    sendByte(8'hF0);
    sendByte(8'h58);
    sendByte(8'h58);
    checkOutput("busy toggle mods", 32'(mods), 32'h0);
    ready = 1'b1;
    expectCmd("busy led byte latest", 8'h00);
    sendByte(8'hFA);
    expectCmd("busy resend ed", 8'hED);
    sendByte(8'hFA);
    expectCmd("busy resend byte", 8'h00);
    sendByte(8'hFA);
    sendByte(8'hF0);
    sendByte(8'h58);

    // Ack just inside the timeout window still advances.
    sendByte(8'h58);
    expectCmd("late ack ed", 8'hED);
    repeat (60) tick();
    sendByte(8'hFA);
    expectCmd("late ack byte", 8'h04);
    sendByte(8'hFA);
    sendByte(8'hF0);
    sendByte(8'h58);

    // No ack at all: the FSM gives up and a later FA is ignored.
    sendByte(8'h58);
    expectCmd("timeout ed", 8'hED);
    repeat (70) tick();
    sendByte(8'hFA);
    expectNoCmd("timeout abort", 10);
    sendByte(8'hF0);
    sendByte(8'h58);
    sendByte(8'h58);
    expectCmd("restart after timeout", 8'hED);
    sendByte(8'hFA);
    expectCmd("restart byte", 8'h04);
    sendByte(8'hFA);
    sendByte(8'hF0);
    sendByte(8'h58);

    // err during the ack wait aborts the handshake.
    sendByte(8'h58);
    expectCmd("err ed", 8'hED);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    sendByte(8'hFA);
    expectNoCmd("err abort", 10);
    sendByte(8'hF0);
    sendByte(8'h58);

    // Reset between ED and the LED byte abandons the update.
    sendByte(8'h58);
    expectCmd("midreset ed", 8'hED);
    ready = 1'b0;
    sendByte(8'hFA);
    reset = 1'b1;
    tick();
    tick();
    checkResetState("midreset");
    reset = 1'b0;
    ready = 1'b1;
    expectNoCmd("midreset no cmd", 20);
    sendByte(8'hFA);
    expectNoCmd("midreset fa ignored", 10);

    // Overflow: the 17th key is dropped and flagged until the next pop.
    for (int i = 0; i < 16; i++) sendByte(8'h1C);
    checkOutput("ovf at 16", 32'(ovf), 32'd0);
    sendByte(8'h1C);
    checkOutput("ovf at 17", 32'(ovf), 32'd1);
    checkOutput("ovf head", 32'(dout), 32'h61);
    popOne();
    checkOutput("ovf cleared by pop", 32'(ovf), 32'd0);
    drainExpect("ovf drain", 15, 8'h61, 0);

    // Pop and push together while full keeps 16 entries and advances the head.
    for (int i = 0; i < 16; i++) sendByte(letter_codes[i]);
    applyStimulus(8'h15, 1'b1, 1'b1, 1'b0);
    checkOutput("full rd+push head", 32'(dout), 32'h62);
    checkOutput("full rd+push ovf", 32'(ovf), 32'd0);
    drainExpect("full rd+push drain", 16, 8'h62, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/kbd_decoder.md
KBD_DECODER -- requirements
Module: kbd_decoder

Interface
REQ-001 clock  in  1  system clock, 25 MHz; all logic on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 kbd  in  8  received scancode byte from the PS/2 controller; valid only while hit=1.
REQ-004 hit  in  1  one-cycle strobe: kbd holds a new byte.
REQ-005 err  in  1  controller receive/transmit error or timeout, level.
REQ-006 ready  in  1  =1: controller accepts a command.
REQ-007 cmd  out  1  one-cycle command strobe to the controller.
REQ-008 dat  out  8  command byte; valid while cmd=1.
REQ-009 rd  in  1  CPU pop strobe for the key FIFO.
REQ-010 dout  out  8  key code at FIFO head, show-ahead; 0x00 when empty.
REQ-011 empty  out  1  =1: FIFO holds no entries.
REQ-012 ovf  out  1  sticky: a key was dropped because the FIFO was full.
REQ-013 mods  out  4  {caps_lock, alt, ctrl, shift} current modifier state.

Function
REQ-014 The prefix FSM has states P_IDLE, P_EXT (after E0), P_BRK (after F0), P_EXTBRK (after E0 F0), and P_SKIP (after E1).
REQ-015 The FSM advances one transition per hit; bytes E0/F0 move to P_EXT/P_BRK (P_EXT+F0 -> P_EXTBRK); any other byte is consumed and returns the FSM to P_IDLE.
REQ-016 P_SKIP discards the next 7 bytes (Pause sequence) via a 3-bit counter, then returns to P_IDLE; it pushes nothing.
REQ-017 Bytes FA, AA, EE, FE, 00, and FF in P_IDLE are never pushed and never change modifiers.
REQ-018 shift = lshift(12) OR rshift(59); ctrl = 14 or E0 14; alt = 11 or E0 11; make sets and break clears each held bit independently.
REQ-019 Caps (58) make toggles caps_lock only if caps was not already held, so typematic repeats are ignored; caps break clears the held bit.
REQ-020 A make of a non-modifier key pushes the translated code; breaks push nothing.
REQ-021 Translation: letters give lowercase ASCII, uppercase if shift XOR caps_lock.
REQ-022 Non-letter printables use the US layout, shifted by shift only.
REQ-023 If ctrl=1, a letter yields (uppercase & 0x1F).
REQ-024 Fixed control codes: Enter 0x0A, Backspace 0x08, Tab 0x09, Esc 0x1B, Delete (E0 71) 0x7F.
REQ-025 Extended codes: Up 0x80, Down 0x81, Left 0x82, Right 0x83, Home 0x84, End 0x85, PgUp 0x86, PgDn 0x87, Insert 0x88, F1..F12 0x90..0x9B.
REQ-026 An unmapped scancode pushes nothing.
REQ-027 Latency: a push decided at the rising edge sampling hit=1 is visible on dout/empty immediately after that edge.
REQ-028 FIFO depth is 16 with 4-bit wrapping pointers and a 5-bit count.
REQ-029 Push when full drops the new code and sets ovf; rd when empty is ignored.
REQ-030 Simultaneous push and rd: when full, both occur and count is unchanged; when empty, only the push occurs.
REQ-031 ovf clears on the first rd that pops an entry.
REQ-032 The LED FSM has states L_IDLE, L_CMD1, L_ACK1, L_CMD2, and L_ACK2.
REQ-033 A caps toggle sets led_pend; in L_IDLE with led_pend=1 the FSM goes to L_CMD1 and clears led_pend.
REQ-034 L_CMDx waits for ready=1, then pulses cmd for one cycle with dat = ED (CMD1) or {5'b0, caps_lock, 2'b0} (CMD2).
REQ-035 L_ACKx advances on hit with kbd=FA: ACK1 -> L_CMD2, ACK2 -> L_IDLE; the FA is not fed to the prefix FSM.
REQ-036 In L_ACKx, a non-FA byte, err=1, or 2^20 cycles without ack aborts to L_IDLE; a non-FA byte is fed to the prefix FSM.
REQ-037 A caps toggle while the LED FSM is busy re-sets led_pend; the resend uses the latest caps_lock.
REQ-038 err=1 forces the prefix FSM to P_IDLE; modifiers and the FIFO are kept.

Reset
REQ-039 reset=1 clears the FIFO, ovf, mods, led_pend, the skip counter, and the timeout counter.
REQ-040 On reset: prefix FSM=P_IDLE, LED FSM=L_IDLE, cmd=0, dat=00, empty=1, dout=00.
REQ-041 Reset mid-sequence (e.g. between ED and the LED byte) abandons it; no cmd is issued after reset until a new caps toggle.

Structure
REQ-042 Package kbd_pkg holds the FSM state encodings, the prefix/ack constants (E0, E1, F0, FA, ED), the special-key codes, and FIFO_DEPTH=16.
REQ-043 Translation is a combinational sub-module kbd_xlat: (scancode, ext, shift, caps, ctrl) -> {valid, code}.

Verification
REQ-044 Shift+letter: hit 12, 1C, F0 1C, F0 12 -> one entry 0x41; mods=0 after the sequence.
REQ-045 Caps/LED: hit 58 -> mods[3]=1 and cmd with dat=ED; ack FA -> cmd with dat=04; ack FA -> L_IDLE.
REQ-046 Extended key: hit E0 75, E0 F0 75 -> one entry 0x80; hit E1 14 77 E1 F0 14 F0 77 -> no entries.
REQ-047 FIFO overflow: 17 makes of 1C without rd -> 16 entries 0x61 and ovf=1; one rd -> ovf=0, count 15.
REQ-048 Ack timeout: caps make with no FA for 2^20 cycles -> LED FSM back to L_IDLE; a next caps make restarts ED.
REQ-049 Concurrent: rd and push in the same cycle while full -> count stays 16; dout advances to the next entry.
